pmp_csr_file: RTL and testbench

- Machine-mode PMP CSR bank for the rocket_big core: holds pmpcfg0/1 and pmpaddr0-7 (8 entries).
- Applies RISC-V lock and WARL rules, and computes the per-entry NAPOT match mask.
- Registered cfg/addr/mask outputs drive the combinational PMP checker directly (entry i maps to checker io_pmp_i_*).
- Sits between the core CSR file (decode/write port) and the PMP checker.

---
 rtl/pmp_csr_file_if.sv | 23 ++
 rtl/pmp_csr_file.sv | 137 +++++++++++++
 tb/tb_pmp_csr_file.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pmp_csr_file_if.sv
// CSR access port between the core CSR file and the PMP CSR bank.
// The core CSR file uses the master side and the PMP bank uses the slave side.
interface pmp_csr_file_if;
  logic [1:0]  csr_priv;
  logic        csr_wen;
  logic        csr_ren;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_illegal;
  logic        pmp_changed;

  modport master (
    output csr_priv, csr_wen, csr_ren, csr_addr, csr_wdata,
    input  csr_rdata, csr_rvalid, csr_illegal, pmp_changed
  );

  modport slave (
    input  csr_priv, csr_wen, csr_ren, csr_addr, csr_wdata,
    output csr_rdata, csr_rvalid, csr_illegal, pmp_changed
  );
endinterface

// File: rtl/pmp_csr_file.sv
// Machine-mode PMP CSR bank: pmpcfg0/1 and pmpaddr0-7 with lock/WARL rules,
// plus registered NAPOT masks that are updated together with the cfg and addr state.
module pmp_csr_file #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ADDR_W      = 30
) (
  input  logic                            clock,
  input  logic                            reset_n,
  pmp_csr_file_if.slave                   bus,
  output logic [NUM_ENTRIES-1:0]          pmp_cfg_l,
  output logic [2*NUM_ENTRIES-1:0]        pmp_cfg_a,
  output logic [NUM_ENTRIES-1:0]          pmp_cfg_x,
  output logic [NUM_ENTRIES-1:0]          pmp_cfg_w,
  output logic [NUM_ENTRIES-1:0]          pmp_cfg_r,
  output logic [ADDR_W*NUM_ENTRIES-1:0]   pmp_addr,
  output logic [32*NUM_ENTRIES-1:0]       pmp_mask
);

  localparam int unsigned CFG_W  = 8;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned T_W    = ADDR_W + 1;
  localparam logic [1:0]  A_TOR  = 2'b01;

  logic [CFG_W-1:0]  cfg_q  [NUM_ENTRIES];
  logic [CFG_W-1:0]  cfg_d  [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_q [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_d [NUM_ENTRIES];
  logic [XLEN-1:0]   mask_q [NUM_ENTRIES];
  logic [XLEN-1:0]   mask_d [NUM_ENTRIES];

  logic                   m_mode, hit_cfg, hit_addr, mapped;
  logic                   wr, rd, bad_priv, changed;
  logic [NUM_ENTRIES-1:0] addr_lock;
  logic [XLEN-1:0]        rdata_d;
  logic [XLEN-1:0]        rdata_q;
  logic                   rvalid_q, illegal_q, changed_q;

  // Reserved bits [6:5] drop; R=0,W=1 is not a legal combination, so W is cleared.
  function automatic logic [CFG_W-1:0] warl_cfg(input logic [CFG_W-1:0] b);
    return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
  endfunction

  function automatic logic [XLEN-1:0] napot_mask(input logic [ADDR_W-1:0] a,
                                                 input logic a0);
    logic [T_W-1:0] t;
    logic [T_W-1:0] m;
    t = {a, a0};
    m = t & ~(t + T_W'(1));
    return XLEN'({m, 2'b11});
  endfunction

  always_comb begin
    m_mode   = (bus.csr_priv == 2'b11);
    hit_cfg  = (bus.csr_addr[11:2] == 10'h0E8);
    hit_addr = (bus.csr_addr[11:4] == 8'h3B);
    mapped   = hit_cfg | hit_addr;
    wr       = bus.csr_wen & mapped & m_mode;
    rd       = bus.csr_ren & mapped & m_mode;
    bad_priv = (bus.csr_wen | bus.csr_ren) & mapped & ~m_mode;
  end

  // Next-state for cfg/addr and the masks derived from that same next state.
  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      addr_lock[i] = cfg_q[i][7];
    end
    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == A_TOR)) addr_lock[i] = 1'b1;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
      if (wr && hit_cfg && (bus.csr_addr[1:0] == 2'(i / 4)) && !cfg_q[i][7])
        cfg_d[i] = warl_cfg(bus.csr_wdata[8*(i%4) +: 8]);
      if (wr && hit_addr && (bus.csr_addr[3:0] == 4'(i)) && !addr_lock[i])
        addr_d[i] = bus.csr_wdata[ADDR_W-1:0];
      if ((cfg_d[i] != cfg_q[i]) || (addr_d[i] != addr_q[i])) changed = 1'b1;
      mask_d[i] = napot_mask(addr_d[i], cfg_d[i][3]);
    end
  end

  // Read mux over pre-edge state; reserved slots read zero.
  always_comb begin
    rdata_d = '0;
    if (hit_cfg && !bus.csr_addr[1]) begin
      for (int b = 0; b < 4; b++) begin
        rdata_d[8*b +: 8] = cfg_q[{bus.csr_addr[0], 2'(b)}];
      end
    end else if (hit_addr && !bus.csr_addr[3]) begin
      rdata_d = XLEN'(addr_q[bus.csr_addr[2:0]]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
        mask_q[i] <= XLEN'(32'h3);
      end
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_q[i]  <= cfg_d[i];
        addr_q[i] <= addr_d[i];
        mask_q[i] <= mask_d[i];
      end
      if (rd) rdata_q <= rdata_d;
      rvalid_q  <= rd;
      illegal_q <= bad_priv;
      changed_q <= wr & changed;
    end
  end

  assign bus.csr_rdata   = rdata_q;
  assign bus.csr_rvalid  = rvalid_q;
  assign bus.csr_illegal = illegal_q;
  assign bus.pmp_changed = changed_q;

  // Flatten per-entry registers onto the checker-facing buses.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      pmp_cfg_l[i]                  = cfg_q[i][7];
      pmp_cfg_a[2*i +: 2]           = cfg_q[i][4:3];
      pmp_cfg_x[i]                  = cfg_q[i][2];
      pmp_cfg_w[i]                  = cfg_q[i][1];
      pmp_cfg_r[i]                  = cfg_q[i][0];
      pmp_addr[ADDR_W*i +: ADDR_W]  = addr_q[i];
      pmp_mask[XLEN*i +: XLEN]      = mask_q[i];
    end
  end

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed bench for pmp_csr_file: a table of CSR accesses with hand-computed
// responses, followed by checks of the final flattened cfg/addr state.
module tb_pmp_csr_file;

  logic           clock;
  logic           reset_n;
  logic [7:0]     cfg_l, cfg_x, cfg_w, cfg_r;
  logic [15:0]    cfg_a;
  logic [239:0]   addr_bus;
  logic [255:0]   mask_bus;

  pmp_csr_file_if bus ();

  pmp_csr_file dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .pmp_cfg_l (cfg_l),
    .pmp_cfg_a (cfg_a),
    .pmp_cfg_x (cfg_x),
    .pmp_cfg_w (cfg_w),
    .pmp_cfg_r (cfg_r),
    .pmp_addr  (addr_bus),
    .pmp_mask  (mask_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [1:0]  priv;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        illegal;
    logic        changed;
    int          midx;
    logic [31:0] mask;
  } vec_t;

  vec_t tv[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t v(logic ren, logic wen, logic [1:0] priv, logic [11:0] addr,
                             logic [31:0] wdata, logic rvalid, logic [31:0] rdata,
                             logic illegal, logic changed, int midx, logic [31:0] mask);
    vec_t r;
    r.ren = ren; r.wen = wen; r.priv = priv; r.addr = addr; r.wdata = wdata;
    r.rvalid = rvalid; r.rdata = rdata; r.illegal = illegal; r.changed = changed;
    r.midx = midx; r.mask = mask;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // ren wen priv addr wdata | rvalid rdata illegal changed | mask entry, mask
    tv.push_back(v(1,0,3,12'h3A0,32'h0,        1,32'h0,        0,0, 0,32'h3));
    tv.push_back(v(1,0,3,12'h3B3,32'h0,        1,32'h0,        0,0, 3,32'h3));
    tv.push_back(v(0,1,3,12'h3B2,32'hFFF,      0,32'h0,        0,1, 2,32'h3));
    tv.push_back(v(0,1,3,12'h3A0,32'h001F0000, 0,32'h0,        0,1, 2,32'h7FFF));
    tv.push_back(v(1,0,3,12'h3A0,32'h0,        1,32'h001F0000, 0,0, 2,32'h7FFF));
    tv.push_back(v(0,1,3,12'h3A0,32'h00170000, 0,32'h001F0000, 0,1, 2,32'h3));
    tv.push_back(v(0,1,3,12'h3A0,32'h00000089, 0,32'h001F0000, 0,1, 0,32'h7));
    tv.push_back(v(0,1,3,12'h3B0,32'h1234,     0,32'h001F0000, 0,0, 0,32'h7));
    tv.push_back(v(1,0,3,12'h3B0,32'h0,        1,32'h0,        0,0, 0,32'h7));
    tv.push_back(v(0,1,3,12'h3A0,32'h00000300, 0,32'h0,        0,1, 0,32'h7));
    tv.push_back(v(1,0,3,12'h3A0,32'h0,        1,32'h00000389, 0,0, 1,32'h3));
    tv.push_back(v(0,1,3,12'h3A0,32'h00000389, 0,32'h00000389, 0,0, 0,32'h7));
    tv.push_back(v(0,1,3,12'h3A1,32'h00008800, 0,32'h00000389, 0,1, 5,32'h7));
    tv.push_back(v(0,1,3,12'h3B4,32'h55,       0,32'h00000389, 0,0, 4,32'h3));
    tv.push_back(v(0,1,3,12'h3B5,32'h55,       0,32'h00000389, 0,0, 5,32'h7));
    tv.push_back(v(0,1,3,12'h3B6,32'h55,       0,32'h00000389, 0,1, 6,32'h3));
    tv.push_back(v(1,0,3,12'h3B6,32'h0,        1,32'h55,       0,0, 6,32'h3));
    tv.push_back(v(1,0,3,12'h3B4,32'h0,        1,32'h0,        0,0, 4,32'h3));
    tv.push_back(v(0,1,3,12'h3A1,32'h00008862, 0,32'h0,        0,0, 4,32'h3));
    tv.push_back(v(1,0,3,12'h3A1,32'h0,        1,32'h00008800, 0,0, 4,32'h3));
    tv.push_back(v(0,1,3,12'h3A1,32'h00008803, 0,32'h00008800, 0,1, 4,32'h3));
    tv.push_back(v(1,0,3,12'h3A1,32'h0,        1,32'h00008803, 0,0, 5,32'h7));
    tv.push_back(v(0,1,0,12'h3B7,32'h77,       0,32'h00008803, 1,0, 7,32'h3));
    tv.push_back(v(1,0,1,12'h3B7,32'h0,        0,32'h00008803, 1,0, 7,32'h3));
    tv.push_back(v(1,0,3,12'h3B7,32'h0,        1,32'h0,        0,0, 7,32'h3));
    tv.push_back(v(1,0,3,12'h3A2,32'h0,        1,32'h0,        0,0, 0,32'h7));
    tv.push_back(v(0,1,3,12'h3A3,32'hFFFFFFFF, 0,32'h0,        0,0, 0,32'h7));
    tv.push_back(v(1,0,3,12'h300,32'h0,        0,32'h0,        0,0, 0,32'h7));
    tv.push_back(v(1,0,0,12'h300,32'h0,        0,32'h0,        0,0, 0,32'h7));
    tv.push_back(v(1,0,3,12'h3BF,32'h0,        1,32'h0,        0,0, 0,32'h7));
    tv.push_back(v(0,1,3,12'h3B1,32'h10,       0,32'h0,        0,1, 1,32'h3));
    tv.push_back(v(1,1,3,12'h3B1,32'h20,       1,32'h10,       0,1, 1,32'h3));
    tv.push_back(v(1,0,3,12'h3B1,32'h0,        1,32'h20,       0,0, 1,32'h3));
    tv.push_back(v(0,1,3,12'h3B3,32'h3FFFFFFF, 0,32'h20,       0,1, 3,32'h3));
    tv.push_back(v(0,1,3,12'h3A0,32'h18000389, 0,32'h20,       0,1, 3,32'hFFFFFFFF));

    reset_n       = 1'b0;
    bus.csr_priv  = 2'b11;
    bus.csr_wen   = 1'b0;
    bus.csr_ren   = 1'b0;
    bus.csr_addr  = 12'h0;
    bus.csr_wdata = 32'h0;
    repeat (3) @(negedge clock);

    check("reset rvalid",  32'(bus.csr_rvalid),  32'h0);
    check("reset rdata",   bus.csr_rdata,        32'h0);
    check("reset illegal", 32'(bus.csr_illegal), 32'h0);
    check("reset changed", 32'(bus.pmp_changed), 32'h0);
    check("reset cfg_a",   32'(cfg_a),           32'h0);
    for (int i = 0; i < 8; i++)
      check($sformatf("reset mask%0d", i), mask_bus[32*i +: 32], 32'h3);
    reset_n = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clock);
      bus.csr_ren   = tv[k].ren;
      bus.csr_wen   = tv[k].wen;
      bus.csr_priv  = tv[k].priv;
      bus.csr_addr  = tv[k].addr;
      bus.csr_wdata = tv[k].wdata;
      @(posedge clock);
      #1;
      check($sformatf("v%0d rvalid", k),  32'(bus.csr_rvalid),  32'(tv[k].rvalid));
      check($sformatf("v%0d rdata", k),   bus.csr_rdata,        tv[k].rdata);
      check($sformatf("v%0d illegal", k), 32'(bus.csr_illegal), 32'(tv[k].illegal));
      check($sformatf("v%0d changed", k), 32'(bus.pmp_changed), 32'(tv[k].changed));
      check($sformatf("v%0d mask%0d", k, tv[k].midx), mask_bus[32*tv[k].midx +: 32], tv[k].mask);
    end

    // Idle cycle: pulses drop, read data holds its last value.
    @(negedge clock);
    bus.csr_ren  = 1'b0;
    bus.csr_wen  = 1'b0;
    bus.csr_priv = 2'b11;
    @(posedge clock);
    #1;
    check("idle rvalid",  32'(bus.csr_rvalid),  32'h0);
    check("idle changed", 32'(bus.pmp_changed), 32'h0);
    check("idle rdata",   bus.csr_rdata,        32'h20);

    check("final cfg_l", 32'(cfg_l), 32'h21);
    check("final cfg_a", 32'(cfg_a), 32'h04C1);
    check("final cfg_x", 32'(cfg_x), 32'h00);
    check("final cfg_w", 32'(cfg_w), 32'h12);
    check("final cfg_r", 32'(cfg_r), 32'h13);
    check("final addr0", 32'(addr_bus[0   +: 30]), 32'h0);
    check("final addr1", 32'(addr_bus[30  +: 30]), 32'h20);
    check("final addr2", 32'(addr_bus[60  +: 30]), 32'hFFF);
    check("final addr3", 32'(addr_bus[90  +: 30]), 32'h3FFFFFFF);
    check("final addr5", 32'(addr_bus[150 +: 30]), 32'h0);
    check("final addr6", 32'(addr_bus[180 +: 30]), 32'h55);
    check("final addr7", 32'(addr_bus[210 +: 30]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
